// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame state encoding, mode constants, default widths
// and the sclk edge-classification helpers used by both ends of the link.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

    localparam logic CPOL_LOW   = 1'b0;
    localparam logic CPHA_LEAD  = 1'b0;

    localparam int DATA_DEF    = 8;
    localparam int COUNTER_DEF = 4;
    localparam int SYNC_DEF    = 2;

    // A leading edge moves sclk away from its idle level, a trailing edge returns to it.
    function automatic logic is_leading(input logic cpol, input logic level,
                                        input logic rise, input logic fall);
        return (rise | fall) & (level ^ cpol);
    endfunction

    function automatic logic is_trailing(input logic cpol, input logic level,
                                         input logic rise, input logic fall);
        return (rise | fall) & ~(level ^ cpol);
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Pin-side and client-side signal bundle of the SPI slave.
interface spi_slave_if #(
    parameter int data = 8
);
    logic            spe;
    logic            cpol;
    logic            cphase;
    logic            sclk;
    logic            ss;
    logic            mosi;
    logic            miso;
    logic            miso_oe;
    logic [data-1:0] s_wdata;
    logic            s_wr;
    logic            s_rd;
    logic [data-1:0] s_rdata;
    logic            RXF;
    logic            SPTEF;
    logic            TXC;
    logic            OVR;

    modport slave (
        input  spe, cpol, cphase, sclk, ss, mosi, s_wdata, s_wr, s_rd,
        output miso, miso_oe, s_rdata, RXF, SPTEF, TXC, OVR
    );

    modport master (
        output spe, cpol, cphase, sclk, ss, mosi, s_wdata, s_wr, s_rd,
        input  miso, miso_oe, s_rdata, RXF, SPTEF, TXC, OVR
    );
endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous pin with single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   sync_stages = 2,
    parameter logic rst_val     = 1'b0
) (
    input  logic clk,
    input  logic preset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [sync_stages-1:0] sync_p;
    logic                   prev_p;

    always_ff @(posedge clk) begin
        if (preset) begin
            sync_p <= {sync_stages{rst_val}};
            prev_p <= rst_val;
        end else begin
            sync_p <= {sync_p[sync_stages-2:0], d};
            prev_p <= sync_p[sync_stages-1];
        end
    end

    assign q    = sync_p[sync_stages-1];
    assign rise = q & ~prev_p;
    assign fall = ~q & prev_p;
endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI slave: all four CPOL/CPHA modes, LSB-first words in both
// directions, TX holding register and RX word register towards a local client.
module spi_slave
    import spi_pkg::*;
#(
    parameter int data        = DATA_DEF,
    parameter int counter     = COUNTER_DEF,
    parameter int sync_stages = SYNC_DEF
) (
    input logic        clk,
    input logic        preset,
    spi_slave_if.slave bus
);
    localparam logic [counter-1:0] LAST_BIT = counter'(data);

    spi_state_e state, state_nxt;

    logic sclk_q, sclk_rise, sclk_fall;
    logic ss_q, ss_rise, ss_fall;
    logic [sync_stages-1:0] mosi_p;
    logic mosi_s;

    logic               cpol_r, cpha_r;
    logic [counter-1:0] cnt, cnt_inc;
    logic [data-1:0]    tx_sr, rx_sr, hold;
    logic               lead, trail, samp_edge, shft_edge;
    logic               load, sample, shift, commit;

    spi_sync_edge #(.sync_stages(sync_stages), .rst_val(1'b0)) u_sclk_sync (
        .clk(clk), .preset(preset), .d(bus.sclk),
        .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.sync_stages(sync_stages), .rst_val(1'b1)) u_ss_sync (
        .clk(clk), .preset(preset), .d(bus.ss),
        .q(ss_q), .rise(ss_rise), .fall(ss_fall)
    );

    // mosi has the same synchronizer depth as sclk so a sample pulse sees an equally aged bit
    assign mosi_s    = mosi_p[sync_stages-1];
    assign lead      = is_leading(cpol_r, sclk_q, sclk_rise, sclk_fall);
    assign trail     = is_trailing(cpol_r, sclk_q, sclk_rise, sclk_fall);
    assign samp_edge = cpha_r ? trail : lead;
    assign shft_edge = cpha_r ? lead : trail;
    assign cnt_inc   = cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (preset) state <= IDLE;
        else        state <= state_nxt;
    end

    // A shift edge at count 0 is either the CPHA=1 "present bit 0" edge or the
    // trailing edge left over from the previous back-to-back frame: never shift there.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        sample    = 1'b0;
        shift     = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                end else if (samp_edge) begin
                    sample = 1'b1;
                    if (cnt_inc == LAST_BIT) state_nxt = DONE;
                end else if (shft_edge && cnt != '0) begin
                    shift = 1'b1;
                end
            end
            DONE: begin
                commit = 1'b1;
                if (!ss_q) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!bus.spe) begin
            state_nxt = IDLE;
            load      = 1'b0;
            sample    = 1'b0;
            shift     = 1'b0;
            commit    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (preset) begin
            cnt         <= '0;
            cpol_r      <= CPOL_LOW;
            cpha_r      <= CPHA_LEAD;
            bus.s_rdata <= '0;
            bus.RXF     <= 1'b0;
            bus.SPTEF   <= 1'b1;
            bus.TXC     <= 1'b0;
            bus.OVR     <= 1'b0;
            bus.miso    <= 1'b0;
            bus.miso_oe <= 1'b0;
        end else begin
            bus.TXC     <= commit;
            bus.miso_oe <= bus.spe && (state != IDLE);
            bus.miso    <= (bus.spe && state != IDLE) ? tx_sr[0] : 1'b0;

            if (load && state == IDLE) begin
                cpol_r <= bus.cpol;
                cphase_latch: cpha_r <= bus.cphase;
            end

            if (load)        cnt <= '0;
            else if (sample) cnt <= cnt_inc;

            if (bus.s_wr)  bus.SPTEF <= 1'b0;
            else if (load) bus.SPTEF <= 1'b1;

            // A read coinciding with the commit frees the register, so the new word lands
            if (commit && (!bus.RXF || bus.s_rd)) begin
                bus.s_rdata <= rx_sr;
                bus.RXF     <= 1'b1;
                if (bus.s_rd) bus.OVR <= 1'b0;
            end else if (commit) begin
                bus.OVR <= 1'b1;
            end else if (bus.s_rd) begin
                bus.RXF <= 1'b0;
                bus.OVR <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        mosi_p <= {mosi_p[sync_stages-2:0], bus.mosi};
        if (bus.s_wr) hold <= bus.s_wdata;
        if (load)       tx_sr <= bus.SPTEF ? '0 : hold;
        else if (shift) tx_sr <= {1'b0, tx_sr[data-1:1]};
        if (sample) rx_sr <= {mosi_s, rx_sr[data-1:1]};
    end
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: fixed mode vectors, overrun/abort/reset sequences and
// random frames against a transaction-level model of the slave.
module tb_spi_slave;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int NS = 2;
    localparam int H  = 8;

    logic clk = 1'b0;
    logic preset = 1'b1;
    always #5 clk = ~clk;

    spi_slave_if #(.data(DW)) bus();

    spi_slave #(.data(DW), .counter(CW), .sync_stages(NS)) dut (
        .clk(clk), .preset(preset), .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int txc_cnt = 0;

    always @(negedge clk) if (bus.TXC) txc_cnt++;

    logic [7:0] m_hold = 8'h00;
    logic [7:0] m_rdata = 8'h00;
    logic [7:0] m_tx = 8'h00;
    bit m_sptef = 1'b1;
    bit m_rxf = 1'b0;
    bit m_ovr = 1'b0;

    typedef struct {
        logic [1:0] mode;
        bit         do_wr;
        logic [7:0] wdata;
        logic [7:0] mosi_w;
        logic [7:0] exp_miso;
        logic [7:0] exp_rdata;
    } vec_t;
    vec_t vt[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: a frame start takes the holding word (zero if empty) and empties it.
    task automatic model_load();
        m_tx = m_sptef ? 8'h00 : m_hold;
        m_sptef = 1'b1;
    endtask

    task automatic model_complete(input logic [7:0] rx);
        if (!m_rxf) begin
            m_rdata = rx;
            m_rxf = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
        model_load();
    endtask

    task automatic do_wr(input logic [7:0] w);
        @(negedge clk);
        bus.s_wr = 1'b1;
        bus.s_wdata = w;
        @(negedge clk);
        bus.s_wr = 1'b0;
        m_hold = w;
        m_sptef = 1'b0;
    endtask

    task automatic do_rd();
        @(negedge clk);
        bus.s_rd = 1'b1;
        @(negedge clk);
        bus.s_rd = 1'b0;
        m_rxf = 1'b0;
        m_ovr = 1'b0;
        tick(1);
    endtask

    task automatic frame(input logic [1:0] mode, input logic [7:0] mo, input int nbits,
                         input bit raise, output logic [7:0] mi, output logic [7:0] exp_tx);
        logic cpol;
        logic cpha;
        cpol = mode[1];
        cpha = mode[0];
        mi = 8'h00;
        if (bus.ss) begin
            bus.cpol = cpol;
            bus.cphase = cpha;
            bus.sclk = cpol;
            tick(H);
            bus.ss = 1'b0;
            model_load();
        end
        exp_tx = m_tx;
        if (!cpha) bus.mosi = mo[0];
        tick(H);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                bus.sclk = ~cpol;
                mi[i] = bus.miso;
                tick(H);
                bus.sclk = cpol;
                if (i + 1 < DW) bus.mosi = mo[i+1];
                tick(H);
            end else begin
                bus.sclk = ~cpol;
                bus.mosi = mo[i];
                tick(H);
                bus.sclk = cpol;
                mi[i] = bus.miso;
                tick(H);
            end
        end
        if (nbits == DW) model_complete(mo);
        if (raise) begin
            bus.ss = 1'b1;
            tick(2 * H);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, 32'(bus.miso), 32'd0);
        check({tag, "_miso_oe"}, 32'(bus.miso_oe), 32'd0);
        check({tag, "_rdata"}, 32'(bus.s_rdata), 32'd0);
        check({tag, "_RXF"}, 32'(bus.RXF), 32'd0);
        check({tag, "_SPTEF"}, 32'(bus.SPTEF), 32'd1);
        check({tag, "_TXC"}, 32'(bus.TXC), 32'd0);
        check({tag, "_OVR"}, 32'(bus.OVR), 32'd0);
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] mi1;
        logic [7:0] etx;
        logic [7:0] mo;
        logic [1:0] cur_mode;
        int t0;

        bus.spe = 1'b1;
        bus.cpol = 1'b0;
        bus.cphase = 1'b0;
        bus.sclk = 1'b0;
        bus.ss = 1'b1;
        bus.mosi = 1'b0;
        bus.s_wdata = 8'h00;
        bus.s_wr = 1'b0;
        bus.s_rd = 1'b0;

        vt[0] = '{2'd0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vt[1] = '{2'd1, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vt[2] = '{2'd2, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vt[3] = '{2'd3, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vt[4] = '{2'd0, 1'b0, 8'h00, 8'h96, 8'h00, 8'h96};

        tick(4);
        check_reset_outputs("reset");
        preset = 1'b0;
        tick(H);

        for (int v = 0; v < 5; v++) begin
            if (vt[v].do_wr) do_wr(vt[v].wdata);
            else check($sformatf("v%0d_SPTEF_pre", v), 32'(bus.SPTEF), 32'd1);
            t0 = txc_cnt;
            frame(vt[v].mode, vt[v].mosi_w, DW, 1'b1, mi, etx);
            check($sformatf("v%0d_master_rx", v), 32'(mi), 32'(vt[v].exp_miso));
            check($sformatf("v%0d_rdata", v), 32'(bus.s_rdata), 32'(vt[v].exp_rdata));
            check($sformatf("v%0d_RXF", v), 32'(bus.RXF), 32'd1);
            check($sformatf("v%0d_OVR", v), 32'(bus.OVR), 32'd0);
            check($sformatf("v%0d_SPTEF", v), 32'(bus.SPTEF), 32'd1);
            check($sformatf("v%0d_TXC_pulses", v), 32'(txc_cnt - t0), 32'd1);
            do_rd();
            check($sformatf("v%0d_RXF_after_rd", v), 32'(bus.RXF), 32'd0);
        end

        // Back-to-back frames with ss held low, second word written after the reload
        do_wr(8'hC3);
        t0 = txc_cnt;
        frame(2'd0, 8'h11, DW, 1'b0, mi1, etx);
        do_wr(8'h77);
        frame(2'd0, 8'h22, DW, 1'b1, mi, etx);
        check("b2b_master_rx1", 32'(mi1), 32'hC3);
        check("b2b_master_rx2", 32'(mi), 32'h00);
        check("b2b_rdata", 32'(bus.s_rdata), 32'h11);
        check("b2b_RXF", 32'(bus.RXF), 32'd1);
        check("b2b_OVR", 32'(bus.OVR), 32'd1);
        check("b2b_SPTEF", 32'(bus.SPTEF), 32'd1);
        check("b2b_TXC_pulses", 32'(txc_cnt - t0), 32'd2);
        do_rd();
        check("b2b_RXF_after_rd", 32'(bus.RXF), 32'd0);
        check("b2b_OVR_after_rd", 32'(bus.OVR), 32'd0);

        // Abort after 4 bits, then a clean frame
        do_wr(8'hE7);
        t0 = txc_cnt;
        frame(2'd0, 8'hFF, 4, 1'b1, mi, etx);
        check("abort_TXC_pulses", 32'(txc_cnt - t0), 32'd0);
        check("abort_RXF", 32'(bus.RXF), 32'd0);
        check("abort_rdata", 32'(bus.s_rdata), 32'h11);
        check("abort_SPTEF", 32'(bus.SPTEF), 32'd1);
        t0 = txc_cnt;
        frame(2'd0, 8'h5A, DW, 1'b1, mi, etx);
        check("post_abort_master_rx", 32'(mi), 32'h00);
        check("post_abort_rdata", 32'(bus.s_rdata), 32'h5A);
        check("post_abort_RXF", 32'(bus.RXF), 32'd1);
        check("post_abort_TXC_pulses", 32'(txc_cnt - t0), 32'd1);

        // Reset in the middle of a mode-3 frame
        do_wr(8'h3A);
        frame(2'd3, 8'h99, 3, 1'b0, mi, etx);
        @(negedge clk);
        preset = 1'b1;
        bus.ss = 1'b1;
        bus.sclk = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        preset = 1'b0;
        m_sptef = 1'b1;
        m_rxf = 1'b0;
        m_ovr = 1'b0;
        m_rdata = 8'h00;
        tick(H);
        do_wr(8'h81);
        t0 = txc_cnt;
        frame(2'd3, 8'h42, DW, 1'b1, mi, etx);
        check("post_reset_master_rx", 32'(mi), 32'h81);
        check("post_reset_rdata", 32'(bus.s_rdata), 32'h42);
        check("post_reset_RXF", 32'(bus.RXF), 32'd1);
        check("post_reset_TXC_pulses", 32'(txc_cnt - t0), 32'd1);

        // Random frames against the model, sometimes back-to-back
        cur_mode = 2'd0;
        for (int r = 0; r < 16; r++) begin
            if (bus.ss) cur_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) do_wr(8'($urandom));
            if ($urandom_range(0, 1) == 1) do_rd();
            mo = 8'($urandom);
            frame(cur_mode, mo, DW, ($urandom_range(0, 3) != 0), mi, etx);
            check($sformatf("rnd%0d_master_rx", r), 32'(mi), 32'(etx));
            check($sformatf("rnd%0d_rdata", r), 32'(bus.s_rdata), 32'(m_rdata));
            check($sformatf("rnd%0d_RXF", r), 32'(bus.RXF), 32'(m_rxf));
            check($sformatf("rnd%0d_OVR", r), 32'(bus.OVR), 32'(m_ovr));
            check($sformatf("rnd%0d_SPTEF", r), 32'(bus.SPTEF), 32'(m_sptef));
        end
        if (!bus.ss) begin
            bus.ss = 1'b1;
            tick(2 * H);
        end
        check("final_miso_oe", 32'(bus.miso_oe), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
